// File: rtl/cpu_pkg.sv
// Shared definitions for the execute stage: ALU operation codes, PC source
// selects, the EX/MEM bundle and the mult/div state encoding.
package cpu_pkg;

  localparam logic [4:0] ALUCTRL_ADD  = 5'd0;
  localparam logic [4:0] ALUCTRL_SUB  = 5'd1;
  localparam logic [4:0] ALUCTRL_AND  = 5'd2;
  localparam logic [4:0] ALUCTRL_OR   = 5'd3;
  localparam logic [4:0] ALUCTRL_XOR  = 5'd4;
  localparam logic [4:0] ALUCTRL_NOR  = 5'd5;
  localparam logic [4:0] ALUCTRL_SLT  = 5'd6;
  localparam logic [4:0] ALUCTRL_SLTU = 5'd7;
  localparam logic [4:0] ALUCTRL_SLL  = 5'd8;
  localparam logic [4:0] ALUCTRL_SRL  = 5'd9;
  localparam logic [4:0] ALUCTRL_SRA  = 5'd10;
  localparam logic [4:0] ALUCTRL_LUI  = 5'd11;
  localparam logic [4:0] ALUCTRL_MULT = 5'd12;
  localparam logic [4:0] ALUCTRL_MULTU= 5'd13;
  localparam logic [4:0] ALUCTRL_DIV  = 5'd14;
  localparam logic [4:0] ALUCTRL_DIVU = 5'd15;
  localparam logic [4:0] ALUCTRL_MFHI = 5'd16;
  localparam logic [4:0] ALUCTRL_MFLO = 5'd17;

  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_BEQ  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

  // Mult/div sequencer states.
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // Registered EX/MEM bundle.
  typedef struct packed {
    logic [31:0] alu_out;
    logic [31:0] wdata;
    logic [31:0] br_target;
    logic [4:0]  wreg;
    logic        memr;
    logic        memw;
    logic        regw;
    logic        mem2r;
    logic        br_taken;
  } ex_mem_t;

  // Codes 12..15 are the iterative multiply/divide operations.
  function automatic logic is_muldiv(input logic [4:0] code);
    return (code >= ALUCTRL_MULT) && (code <= ALUCTRL_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers. Shift-add multiply,
// restoring divide, both on operand magnitudes with a final sign fixup.
// Only present when MULDIV_EN is defined.
`ifdef MULDIV_EN
module muldiv_unit #(
  parameter int XLEN      = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  import cpu_pkg::*;

  localparam int CW = $clog2(MD_CYCLES);

  md_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d;   // product upper half / partial remainder
  logic [XLEN-1:0] low_q, low_d;   // multiplier->product lower / dividend->quotient
  logic [XLEN-1:0] dvs_q, dvs_d;   // multiplicand / divisor magnitude
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic            is_div_q, is_div_d;
  logic            neg_q_q, neg_q_d;  // negate product or quotient
  logic            neg_r_q, neg_r_d;  // negate remainder
  logic            div0_q, div0_d;

  logic            signed_op, a_neg, b_neg;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic            sub_ok;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] quo, rem;

  // Sequencer state, iteration datapath and HI/LO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      low_q    <= '0;
      dvs_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      low_q    <= low_d;
      dvs_q    <= dvs_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      div0_q   <= div0_d;
    end
  end

  // Next state, one multiply/divide step per BUSY cycle, result commit in DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    low_d    = low_q;
    dvs_d    = dvs_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    div0_d   = div0_q;

    signed_op = ~op[0];
    a_neg     = signed_op & a[XLEN-1];
    b_neg     = signed_op & b[XLEN-1];

    sum     = {1'b0, acc_q} + {1'b0, dvs_q & {XLEN{low_q[0]}}};
    shifted = {acc_q, low_q[XLEN-1]};
    sub_ok  = shifted >= {1'b0, dvs_q};

    prod = {acc_q, low_q};
    if (neg_q_q) prod = -prod;
    quo = neg_q_q ? -low_q : low_q;
    rem = neg_r_q ? -acc_q : acc_q;

    case (state_q)
      MD_IDLE: begin
        if (start && !flush) begin
          state_d  = MD_BUSY;
          cnt_d    = CW'(MD_CYCLES - 1);
          acc_d    = '0;
          low_d    = a_neg ? -a : a;
          dvs_d    = b_neg ? -b : b;
          is_div_d = op[1];
          neg_q_d  = a_neg ^ b_neg;
          neg_r_d  = a_neg;
          div0_d   = (b == '0);
        end
      end
      MD_BUSY: begin
        if (flush) begin
          state_d = MD_IDLE;
        end else begin
          if (is_div_q) begin
            if (sub_ok) begin
              acc_d = XLEN'(shifted - {1'b0, dvs_q});
              low_d = {low_q[XLEN-2:0], 1'b1};
            end else begin
              acc_d = shifted[XLEN-1:0];
              low_d = {low_q[XLEN-2:0], 1'b0};
            end
          end else begin
            acc_d = sum[XLEN:1];
            low_d = {sum[0], low_q[XLEN-1:1]};
          end
          if (cnt_q == '0) state_d = MD_DONE;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      MD_DONE: begin
        state_d = MD_IDLE;
        if (!flush) begin
          if (is_div_q) begin
            hi_d = rem;
            lo_d = quo;
            if (div0_q) lo_d = '1;
          end else begin
            hi_d = prod[2*XLEN-1:XLEN];
            lo_d = prod[XLEN-1:0];
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  assign busy = (state_q == MD_BUSY);
  assign done = (state_q == MD_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`endif

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, branch/jump resolution and the EX/MEM
// register. The iterative mult/div unit with HI/LO is included when the
// MULDIV_EN macro is defined; otherwise codes 12..15 become bubbles,
// MFHI/MFLO read 0 and stall_req is held low.
module ex_stage #(
  parameter int XLEN      = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic [XLEN-1:0] pc,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  input  logic [XLEN-1:0] imm32,
  input  logic [4:0]      aluctrl,
  input  logic            alusrc,
  input  logic            regdst,
  input  logic [1:0]      pcsrc,
  input  logic            memr,
  input  logic            memw,
  input  logic            regw,
  input  logic            mem2r,
  input  logic            pcwr,
  output logic [XLEN-1:0] alu_out,
  output logic [XLEN-1:0] wdata,
  output logic [4:0]      wreg,
  output logic            memr_o,
  output logic            memw_o,
  output logic            regw_o,
  output logic            mem2r_o,
  output logic            br_taken,
  output logic [XLEN-1:0] br_target,
  output logic            stall_req
);
  import cpu_pkg::*;

  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic [4:0]      shamt;
  logic            br_c;
  logic [XLEN-1:0] tgt_c;
  logic [XLEN-1:0] hi_val, lo_val;
  logic            md_op_in;
  logic            bubble;
  ex_mem_t         exm_q, exm_d;
  logic            unused_ok;

  assign md_op_in  = is_muldiv(aluctrl);
  assign unused_ok = ^{pcwr, instr[31:26]};

`ifdef MULDIV_EN
  logic md_busy, md_done;

  muldiv_unit #(
    .XLEN      (XLEN),
    .MD_CYCLES (MD_CYCLES)
  ) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (md_op_in),
    .op    (aluctrl[1:0]),
    .a     (rd1),
    .b     (rd2),
    .flush (flush),
    .busy  (md_busy),
    .done  (md_done),
    .hi    (hi_val),
    .lo    (lo_val)
  );

  assign stall_req = md_busy | md_done | md_op_in;
  assign bubble    = flush | stall_req;
`else
  assign hi_val    = '0;
  assign lo_val    = '0;
  assign stall_req = 1'b0;
  assign bubble    = flush | md_op_in;
`endif

  // Single-cycle ALU result.
  always_comb begin
    op_b    = alusrc ? imm32 : rd2;
    shamt   = instr[10:6];
    alu_res = '0;
    case (aluctrl)
      ALUCTRL_ADD:  alu_res = rd1 + op_b;
      ALUCTRL_SUB:  alu_res = rd1 - op_b;
      ALUCTRL_AND:  alu_res = rd1 & op_b;
      ALUCTRL_OR:   alu_res = rd1 | op_b;
      ALUCTRL_XOR:  alu_res = rd1 ^ op_b;
      ALUCTRL_NOR:  alu_res = ~(rd1 | op_b);
      ALUCTRL_SLT:  alu_res[0] = $signed(rd1) < $signed(op_b);
      ALUCTRL_SLTU: alu_res[0] = rd1 < op_b;
      ALUCTRL_SLL:  alu_res = op_b << shamt;
      ALUCTRL_SRL:  alu_res = op_b >> shamt;
      ALUCTRL_SRA:  alu_res = XLEN'($signed(op_b) >>> shamt);
      ALUCTRL_LUI:  alu_res = op_b << 16;
      ALUCTRL_MFHI: alu_res = hi_val;
      ALUCTRL_MFLO: alu_res = lo_val;
      default:      alu_res = '0;
    endcase
  end

  // Branch / jump resolution.
  always_comb begin
    br_c  = 1'b0;
    tgt_c = '0;
    case (pcsrc)
      PCSRC_BEQ: begin
        if (rd1 == rd2) begin
          br_c  = 1'b1;
          tgt_c = pc + 32'd4 + (imm32 << 2);
        end
      end
      PCSRC_JUMP: begin
        br_c  = 1'b1;
        tgt_c = {pc[31:28], instr[25:0], 2'b00};
      end
      default: begin
        br_c  = 1'b0;
        tgt_c = '0;
      end
    endcase
  end

  // Next EX/MEM contents; bubbles carry all zeros.
  always_comb begin
    exm_d = '0;
    if (!bubble) begin
      exm_d.alu_out   = alu_res;
      exm_d.wdata     = rd2;
      exm_d.br_target = tgt_c;
      exm_d.wreg      = regdst ? instr[15:11] : instr[20:16];
      exm_d.memr      = memr;
      exm_d.memw      = memw;
      exm_d.regw      = regw;
      exm_d.mem2r     = mem2r;
      exm_d.br_taken  = br_c;
    end
  end

  // EX/MEM pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) exm_q <= '0;
    else        exm_q <= exm_d;
  end

  assign alu_out   = exm_q.alu_out;
  assign wdata     = exm_q.wdata;
  assign wreg      = exm_q.wreg;
  assign memr_o    = exm_q.memr;
  assign memw_o    = exm_q.memw;
  assign regw_o    = exm_q.regw;
  assign mem2r_o   = exm_q.mem2r;
  assign br_taken  = exm_q.br_taken;
  assign br_target = exm_q.br_target;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases with literal expectations
// followed by randomized traffic compared every cycle against a behavioural
// model. Expectations follow MULDIV_EN the same way the design does.
module tb_ex_stage;
  localparam int MD_CYCLES = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush;
  logic [31:0] pc, instr, rd1, rd2, imm32;
  logic [4:0]  aluctrl;
  logic        alusrc, regdst;
  logic [1:0]  pcsrc;
  logic        memr, memw, regw, mem2r, pcwr;
  logic [31:0] alu_out, wdata, br_target;
  logic [4:0]  wreg;
  logic        memr_o, memw_o, regw_o, mem2r_o, br_taken, stall_req;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_stage #(.XLEN(32), .MD_CYCLES(MD_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .pc(pc), .instr(instr),
    .rd1(rd1), .rd2(rd2), .imm32(imm32), .aluctrl(aluctrl), .alusrc(alusrc),
    .regdst(regdst), .pcsrc(pcsrc), .memr(memr), .memw(memw), .regw(regw),
    .mem2r(mem2r), .pcwr(pcwr), .alu_out(alu_out), .wdata(wdata), .wreg(wreg),
    .memr_o(memr_o), .memw_o(memw_o), .regw_o(regw_o), .mem2r_o(mem2r_o),
    .br_taken(br_taken), .br_target(br_target), .stall_req(stall_req)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] alu, wdata, tgt;
    logic [4:0]  wreg;
    logic        memr, memw, regw, mem2r, br;
  } out_t;

  out_t        exp_q;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_rem;   // stalled cycles still to come after the start cycle
  logic        md_op_in;

  assign md_op_in = (aluctrl >= 5'd12) && (aluctrl <= 5'd15);

  function automatic logic [63:0] md_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'd0: return sa * sb;
      2'd1: return ua * ub;
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  function automatic out_t calc(input logic bub);
    out_t o;
    logic [31:0] b;
    o = '0;
    if (bub) return o;
    b = alusrc ? imm32 : rd2;
    case (aluctrl)
      5'd0:  o.alu = rd1 + b;
      5'd1:  o.alu = rd1 - b;
      5'd2:  o.alu = rd1 & b;
      5'd3:  o.alu = rd1 | b;
      5'd4:  o.alu = rd1 ^ b;
      5'd5:  o.alu = ~(rd1 | b);
      5'd6:  o.alu = ($signed(rd1) < $signed(b)) ? 32'd1 : 32'd0;
      5'd7:  o.alu = (rd1 < b) ? 32'd1 : 32'd0;
      5'd8:  o.alu = b << instr[10:6];
      5'd9:  o.alu = b >> instr[10:6];
      5'd10: o.alu = 32'($signed(b) >>> instr[10:6]);
      5'd11: o.alu = {b[15:0], 16'd0};
      5'd16: o.alu = m_hi;
      5'd17: o.alu = m_lo;
      default: o.alu = 32'd0;
    endcase
    o.wdata = rd2;
    o.wreg  = regdst ? instr[15:11] : instr[20:16];
    o.memr  = memr;
    o.memw  = memw;
    o.regw  = regw;
    o.mem2r = mem2r;
    if (pcsrc == 2'b01 && rd1 == rd2) begin
      o.br  = 1'b1;
      o.tgt = pc + 32'd4 + imm32 * 32'd4;
    end else if (pcsrc == 2'b10) begin
      o.br  = 1'b1;
      o.tgt = {pc[31:28], instr[25:0], 2'b00};
    end
    return o;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q <= '0;
      m_hi  <= '0;
      m_lo  <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      m_rem <= 0;
    end else begin
`ifdef MULDIV_EN
      exp_q <= calc(flush || (m_rem != 0) || md_op_in);
      if (flush) begin
        m_rem <= 0;
      end else if (m_rem != 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_hi <= p_hi;
          m_lo <= p_lo;
        end
      end else if (md_op_in) begin
        m_rem <= MD_CYCLES + 1;
        {p_hi, p_lo} <= md_result(aluctrl[1:0], rd1, rd2);
      end
`else
      exp_q <= calc(flush || md_op_in);
`endif
    end
  end

  logic exp_stall;
`ifdef MULDIV_EN
  assign exp_stall = (m_rem != 0) || md_op_in;
`else
  assign exp_stall = 1'b0;
`endif

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("alu_out",   alu_out,          exp_q.alu);
    chk("wdata",     wdata,            exp_q.wdata);
    chk("br_target", br_target,        exp_q.tgt);
    chk("wreg",      {27'd0, wreg},    {27'd0, exp_q.wreg});
    chk("ctrl",      {27'd0, memr_o, memw_o, regw_o, mem2r_o, br_taken},
                     {27'd0, exp_q.memr, exp_q.memw, exp_q.regw, exp_q.mem2r, exp_q.br});
    chk("stall_req", {31'd0, stall_req}, {31'd0, exp_stall});
  end

  // ---------------- stimulus ----------------
  task automatic bubble_in();
    flush = 0; pc = 0; instr = 0; rd1 = 0; rd2 = 0; imm32 = 0; aluctrl = 0;
    alusrc = 0; regdst = 0; pcsrc = 0; memr = 0; memw = 0; regw = 0; mem2r = 0; pcwr = 0;
  endtask

  // Counts cycles with stall_req high, starting from the cycle whose inputs
  // are currently applied; subsequent cycles are fed bubbles.
  task automatic run_md(input string name, input int exp_len);
    int n;
    n = 0;
    #1;
    while (stall_req === 1'b1 && n < 100) begin
      n++;
      @(posedge clk); #1;
      bubble_in();
      #1;
    end
    chk(name, n, exp_len);
  endtask

  task automatic read_hilo(input string name, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    bubble_in(); aluctrl = 5'd17; regw = 1;
    @(posedge clk); #1;
    chk({name, "_lo"}, alu_out, exp_lo);
    aluctrl = 5'd16;
    @(posedge clk); #1;
    chk({name, "_hi"}, alu_out, exp_hi);
    bubble_in();
  endtask

  function automatic logic [31:0] rand_val();
    int unsigned s;
    s = $urandom_range(0, 9);
    case (s)
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bubble_in();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alu_out", alu_out, 32'd0);
    chk("rst_br", {31'd0, br_taken}, 32'd0);
    chk("rst_regw", {31'd0, regw_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    rst_n = 1;

    // ADD wraparound with rd destination
    aluctrl = 5'd0; rd1 = 32'h7FFF_FFFF; rd2 = 32'd1; regdst = 1;
    instr = 32'd5 << 11; regw = 1;
    @(posedge clk); #1;
    chk("add_res", alu_out, 32'h8000_0000);
    chk("add_wreg", {27'd0, wreg}, 32'd5);
    chk("add_regw", {31'd0, regw_o}, 32'd1);

    // beq taken / not taken
    bubble_in(); aluctrl = 5'd1; pcsrc = 2'b01; rd1 = 3; rd2 = 3; pc = 32'h100; imm32 = 4;
    @(posedge clk); #1;
    chk("beq_taken", {31'd0, br_taken}, 32'd1);
    chk("beq_target", br_target, 32'h114);
    rd2 = 4;
    @(posedge clk); #1;
    chk("beq_nt", {31'd0, br_taken}, 32'd0);
    chk("beq_nt_tgt", br_target, 32'd0);

`ifdef MULDIV_EN
    bubble_in(); aluctrl = 5'd12; rd1 = -32'sd3; rd2 = 32'd7; regw = 1;
    run_md("mult_stall", MD_CYCLES + 2);
    read_hilo("mult", 32'hFFFF_FFEB, 32'hFFFF_FFFF);

    bubble_in(); aluctrl = 5'd14; rd1 = -32'sd7; rd2 = 32'd2;
    run_md("div_stall", MD_CYCLES + 2);
    read_hilo("div", 32'hFFFF_FFFD, 32'hFFFF_FFFF);

    bubble_in(); aluctrl = 5'd15; rd1 = 32'd9; rd2 = 32'd0;
    run_md("divu0_stall", MD_CYCLES + 2);
    read_hilo("divu0", 32'hFFFF_FFFF, 32'd9);

    // flush while the counter reads 10
    bubble_in(); aluctrl = 5'd12; rd1 = 32'd5; rd2 = 32'd6;
    @(posedge clk); #1;
    bubble_in();
    repeat (21) @(posedge clk);
    #1 flush = 1;
    @(posedge clk); #1;
    flush = 0;
    #1 chk("flush_stall", {31'd0, stall_req}, 32'd0);
    read_hilo("flush", 32'hFFFF_FFFF, 32'd9);

    // asynchronous reset in the middle of BUSY
    bubble_in(); aluctrl = 5'd13; rd1 = 32'd11; rd2 = 32'd13;
    @(posedge clk); #1;
    bubble_in();
    repeat (5) @(posedge clk);
    #1 chk("busy_stall", {31'd0, stall_req}, 32'd1);
    #1 rst_n = 0;
    #1;
    chk("arst_stall", {31'd0, stall_req}, 32'd0);
    chk("arst_alu", alu_out, 32'd0);
    chk("arst_ctrl", {27'd0, memr_o, memw_o, regw_o, mem2r_o, br_taken}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    read_hilo("arst", 32'd0, 32'd0);
`else
    bubble_in(); aluctrl = 5'd12; rd1 = -32'sd3; rd2 = 32'd7; regw = 1; memr = 1;
    #1 chk("nomd_stall", {31'd0, stall_req}, 32'd0);
    @(posedge clk); #1;
    chk("nomd_regw", {31'd0, regw_o}, 32'd0);
    chk("nomd_memr", {31'd0, memr_o}, 32'd0);
    bubble_in(); aluctrl = 5'd16; regw = 1;
    @(posedge clk); #1;
    chk("nomd_mfhi", alu_out, 32'd0);
    chk("nomd_mfhi_regw", {31'd0, regw_o}, 32'd1);
    bubble_in();
`endif

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      int unsigned r;
      @(posedge clk); #1;
      r = $urandom_range(0, 99);
      if (r < 8)       aluctrl = 5'($urandom_range(12, 15));
      else if (r < 14) aluctrl = 5'($urandom_range(18, 31));
      else begin
        aluctrl = 5'($urandom_range(0, 13));
        if (aluctrl == 5'd12) aluctrl = 5'd16;
        if (aluctrl == 5'd13) aluctrl = 5'd17;
      end
      rd1    = rand_val();
      rd2    = ($urandom_range(0, 3) == 0) ? rd1 : rand_val();
      imm32  = rand_val();
      pc     = $urandom;
      instr  = $urandom;
      alusrc = 1'($urandom_range(0, 1));
      regdst = 1'($urandom_range(0, 1));
      pcsrc  = 2'($urandom_range(0, 3));
      {memr, memw, regw, mem2r, pcwr} = 5'($urandom);
      flush  = ($urandom_range(0, 11) == 0);
    end

    @(posedge clk); #1;
    bubble_in();
    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the multicycle/pipelined MIPS-style CPU; consumes the ID/EX register outputs and produces the registered EX/MEM bundle.
- Contains a single-cycle ALU, branch/jump resolution, and an iterative 32-cycle multiply/divide unit with HI/LO registers.
- While a multiply or divide is running, it asserts `stall_req` to the hazard logic.

Parameters:
- XLEN, 32, datapath width.
- MD_CYCLES, 32, iteration count of the mult/div unit (equal to XLEN).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  kills the current EX op and any in-flight mult/div.
- pc  in  32  PC of the instruction.
- instr  in  32  instruction word.
- rd1, rd2  in  32 each  register operands.
- imm32  in  32  sign-extended immediate.
- aluctrl  in  5  operation code.
- alusrc  in  1  1 = operand B is imm32.
- regdst  in  1  1 = destination is instr[15:11], else instr[20:16].
- pcsrc  in  2  00 seq, 01 beq, 10 jump.
- memr, memw, regw, mem2r, pcwr  in  1 each  control bits passed through.
- alu_out  out  32  registered result.
- wdata  out  32  registered rd2 (store data).
- wreg  out  5  registered destination register.
- memr_o, memw_o, regw_o, mem2r_o  out  1 each  registered control bits.
- br_taken  out  1  registered redirect.
- br_target  out  32  registered target.
- stall_req  out  1  combinational; high while the mult/div unit is busy.

Behaviour:
- Reset: all outputs 0, HI=LO=0, FSM IDLE. Reset mid-operation aborts immediately.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed), 7 SLTU.
  - 8 SLL, 9 SRL, 10 SRA: shift B by instr[10:6].
  - 11 LUI: B<<16.
  - 12 MULT, 13 MULTU, 14 DIV, 15 DIVU.
  - 16 MFHI, 17 MFLO.
  - Other codes produce a result of 0.
- Arithmetic: 32-bit wraparound; no overflow trap.
- Single-cycle ops: outputs register on the next rising edge, latency 1.
- Branch targets:
  - beq: taken when rd1==rd2; target = pc+4+(imm32<<2).
  - jump: always taken; target = {pc[31:28], instr[25:0], 2'b00}.
  - Not taken: br_target=0.
- Mult/div FSM (IDLE, BUSY, DONE):
  - IDLE→BUSY when the op is 12–15 and flush=0. Capture operands internally; the input bundle is don't-care from then on, because ID/EX supplies bubbles while stalled.
  - BUSY: counter runs MD_CYCLES-1 down to 0. Multiply is shift-add; divide is restoring. Signed ops use magnitudes with sign fixup: quotient sign = sign(a) XOR sign(b), remainder sign = sign(dividend). BUSY→DONE at count 0.
  - DONE: HI/LO written (mult: HI=upper, LO=lower; div: LO=quotient, HI=remainder). DONE→IDLE next cycle.
  - stall_req=1 in the start cycle, throughout BUSY, and in DONE; 0 only in IDLE with no mult/div op on the input.
  - Total stall = MD_CYCLES+2 cycles.
  - EX/MEM output is a bubble (all control bits 0) for the mult/div instruction and every stalled cycle.
- Divide by zero: LO=32'hFFFF_FFFF, HI=dividend; takes the same latency.
- flush:
  - Forces the registered outputs to a bubble next edge.
  - In BUSY/DONE, returns the FSM to IDLE without writing HI/LO.
  - flush in the start cycle prevents the start.
- MFHI/MFLO in the same cycle as DONE: impossible, because stall holds them in ID.
- Priority: rst_n > flush > normal.

Optional Feature:
- Macro MULDIV_EN.
- Defined: mult/div unit and HI/LO are present as described.
- Undefined: codes 12–15 act as NOPs (bubble), MFHI/MFLO return 0, stall_req is tied 0, and no FSM is synthesized.

Decomposition:
- Shared package `cpu_pkg`:
  - ALUCTRL_* localparams (5-bit).
  - PCSRC_SEQ/BEQ/JUMP.
  - MD state encoding (IDLE/BUSY/DONE).
- Sub-module `muldiv_unit`:
  - Ports: start, op[1:0], a, b, flush, busy, done, hi, lo.
  - Contains the FSM and counter.
  - Instantiated only under MULDIV_EN.

Test Plan:
- ADD rd1=32'h7FFF_FFFF, rd2=1, regdst=1, instr[15:11]=5 -> next edge: alu_out=32'h8000_0000, wreg=5, regw_o copied.
- beq rd1=rd2=3, pc=32'h100, imm32=4 -> br_taken=1, br_target=32'h114. Same with rd2=4 -> br_taken=0.
- MULT rd1=-3, rd2=7 -> stall_req high 34 cycles; then MFLO=32'hFFFF_FFEB, MFHI=32'hFFFF_FFFF.
- DIV rd1=-7, rd2=2 -> LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF. DIVU by 0 with rd1=9 -> LO=32'hFFFF_FFFF, HI=9.
- flush asserted at BUSY count 10 -> stall_req drops next cycle, HI/LO keep prior values; assert rst_n=0 mid-BUSY -> all outputs 0 immediately.
- Build without MULDIV_EN: MULT -> stall_req never high, outputs bubble; MFHI -> alu_out=0.
